// File: rtl/counter_mon_defs.sv
// Shared definitions for the four-bit wrap monitor: state codes, step
// classification and the helper that classifies one sampled step.
package counter_mon_defs;

    localparam int Q_W = 4;
    localparam logic [Q_W-1:0] Q_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } mon_state_t;

    // How the newest sample relates to the previous one.
    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_NEXT,
        STEP_RESTART,
        STEP_ILLEGAL
    } step_kind_t;

    // Classify a prev -> cur transition of a free-running 4-bit up counter.
    // A 15 -> 0 transition falls out as STEP_NEXT because the increment wraps.
    function automatic step_kind_t classify_step(input logic [Q_W-1:0] prev,
                                                 input logic [Q_W-1:0] cur);
        logic [Q_W-1:0] nxt;
        nxt = prev + 4'd1;
        if (cur == prev) begin
            return STEP_HOLD;
        end
        if (cur == nxt) begin
            return STEP_NEXT;
        end
        if (cur == '0) begin
            return STEP_RESTART;
        end
        return STEP_ILLEGAL;
    endfunction

endpackage

// File: rtl/four_bit_wrap_monitor_if.sv
// Bus between the upstream-counter side and the wrap monitor.
// master: drives count/compare/clear and observes results.
// slave:  the monitor itself.
interface four_bit_wrap_monitor_if #(parameter int WRAP_W = 8);

    logic [counter_mon_defs::Q_W-1:0] q;
    logic [counter_mon_defs::Q_W-1:0] match;
    logic                             clear;
    logic                             wrap_tick;
    logic                             match_tick;
    logic [WRAP_W-1:0]                wrap_cnt;
    logic                             wrap_sat;
    logic                             step_err;
    logic                             fault;

    modport master (
        output q, match, clear,
        input  wrap_tick, match_tick, wrap_cnt, wrap_sat, step_err, fault
    );

    modport slave (
        input  q, match, clear,
        output wrap_tick, match_tick, wrap_cnt, wrap_sat, step_err, fault
    );

endinterface

// File: rtl/q_sync2.sv
// Two-flop sampler bringing the asynchronous upstream count into the clk
// domain. Both stages are exposed: s2 is the decision value, s1 is what s2
// will hold after the next edge.
module q_sync2
    import counter_mon_defs::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [Q_W-1:0] d,
    output logic [Q_W-1:0] s1,
    output logic [Q_W-1:0] s2
);

    logic [Q_W-1:0] s1_q;
    logic [Q_W-1:0] s2_q;

    // Sampler pipeline, cleared asynchronously.
    // NOTE: non-blocking assignments let s2_q take the old s1_q on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign s1 = s1_q;
    assign s2 = s2_q;

endmodule

// File: rtl/four_bit_wrap_monitor.sv
// Watches a 4-bit up counter running in another clock domain. After
// synchronisation it checks every step: legal increments and 15->0 wraps are
// accepted (with wrap and match pulses), a jump to 0 is taken as an upstream
// restart, anything else is a fault that holds until clear.
module four_bit_wrap_monitor
    import counter_mon_defs::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    four_bit_wrap_monitor_if.slave   mon
);

    localparam logic [WRAP_W-1:0] CNT_MAX = '1;

    logic [Q_W-1:0]    s1;
    logic [Q_W-1:0]    s2;

    mon_state_t        state_q, state_d;
    logic              warm_q, warm_d;
    logic [Q_W-1:0]    prev_q, prev_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_sat_q, wrap_sat_d;
    logic              wrap_tick_q, wrap_tick_d;
    logic              match_tick_q, match_tick_d;
    logic              step_err_q, step_err_d;
    logic              fault_q, fault_d;
    step_kind_t        step;

    q_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mon.q),
        .s1    (s1),
        .s2    (s2)
    );

    // Relation of the synchronised sample to the last accepted value.
    always_comb begin
        step = classify_step(prev_q, s2);
    end

    // FSM next state, prev tracking and per-step pulses.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        warm_d       = 1'b1;
        wrap_tick_d  = 1'b0;
        match_tick_d = 1'b0;
        step_err_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                // warm_q marks that s1 holds a real sample; loading prev from s1
                // on the same edge s2 takes that sample keeps prev == s2.
                if (warm_q) begin
                    prev_d  = s1;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                case (step)
                    STEP_HOLD: begin
                    end
                    STEP_NEXT: begin
                        prev_d       = s2;
                        wrap_tick_d  = (prev_q == Q_MAX);
                        match_tick_d = (s2 == mon.match);
                    end
                    STEP_RESTART: begin
                        prev_d = '0;
                    end
                    default: begin
                        prev_d     = s2;
                        step_err_d = 1'b1;
                        state_d    = ST_FAULT;
                    end
                endcase
            end
            ST_FAULT: begin
                if (mon.clear) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        fault_d = (state_d == ST_FAULT);
    end

    // Saturating wrap counter; clear has the last word, even against a wrap.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_tick_d && (wrap_cnt_q != CNT_MAX)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
        if (mon.clear) begin
            wrap_cnt_d = '0;
        end
        wrap_sat_d = mon.clear ? 1'b0 : (wrap_sat_q | (wrap_cnt_d == CNT_MAX));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            warm_q       <= 1'b0;
            prev_q       <= '0;
            wrap_cnt_q   <= '0;
            wrap_sat_q   <= 1'b0;
            wrap_tick_q  <= 1'b0;
            match_tick_q <= 1'b0;
            step_err_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_q       <= warm_d;
            prev_q       <= prev_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_sat_q   <= wrap_sat_d;
            wrap_tick_q  <= wrap_tick_d;
            match_tick_q <= match_tick_d;
            step_err_q   <= step_err_d;
            fault_q      <= fault_d;
        end
    end

    assign mon.wrap_tick  = wrap_tick_q;
    assign mon.match_tick = match_tick_q;
    assign mon.wrap_cnt   = wrap_cnt_q;
    assign mon.wrap_sat   = wrap_sat_q;
    assign mon.step_err   = step_err_q;
    assign mon.fault      = fault_q;

endmodule

// File: tb/tb_four_bit_wrap_monitor.sv
// Self-checking bench: two monitors (8-bit and 2-bit wrap counters) see the
// same upstream count. A reference model derived from the step rules predicts
// every output each cycle; directed checks cover the headline scenarios.
module tb_four_bit_wrap_monitor;
    import counter_mon_defs::*;

    localparam int CLK_P = 10;
    localparam int MAX8  = 255;
    localparam int MAX2  = 3;

    logic       clk;
    logic       reset;
    logic [3:0] q_drv;
    logic [3:0] match_drv;
    logic       clear_drv;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_wraps8 = 0;
    int obs_wraps2 = 0;
    int obs_match8 = 0;
    int obs_err8   = 0;

    four_bit_wrap_monitor_if #(.WRAP_W(8)) bus8 ();
    four_bit_wrap_monitor_if #(.WRAP_W(2)) bus2 ();

    assign bus8.q     = q_drv;
    assign bus8.match = match_drv;
    assign bus8.clear = clear_drv;
    assign bus2.q     = q_drv;
    assign bus2.match = match_drv;
    assign bus2.clear = clear_drv;

    four_bit_wrap_monitor #(.WRAP_W(8)) dut8 (.clk(clk), .reset(reset), .mon(bus8));
    four_bit_wrap_monitor #(.WRAP_W(2)) dut2 (.clk(clk), .reset(reset), .mon(bus2));

    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    // ---------------- reference model ----------------
    mon_state_t m_state = ST_INIT;
    int         m_edges = 0;
    int         m_prev  = 0;
    int         qh[$];
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;
    bit         m_sat8 = 0;
    bit         m_sat2 = 0;
    bit         m_wrap = 0;
    bit         m_match = 0;
    bit         m_err = 0;

    task automatic model_reset();
        m_state = ST_INIT;
        m_edges = 0;
        m_prev  = 0;
        qh.delete();
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_sat8 = 0;
        m_sat2 = 0;
        m_wrap = 0;
        m_match = 0;
        m_err = 0;
    endtask

    // One clock edge: qh[0] is q sampled now, qh[1] one edge ago, qh[2] two.
    task automatic model_edge();
        int cur;
        int diff;
        bit legal;
        qh.push_front(int'(q_drv));
        if (qh.size() > 3) void'(qh.pop_back());
        m_edges++;
        m_wrap = 0;
        m_match = 0;
        m_err = 0;
        legal = 0;
        case (m_state)
            ST_INIT: begin
                if (m_edges >= 2) begin
                    m_prev  = qh[1];
                    m_state = ST_TRACK;
                end
            end
            ST_TRACK: begin
                cur  = qh[2];
                diff = (cur + 16 - m_prev) % 16;
                if (diff == 1) begin
                    legal  = 1;
                    m_wrap = (m_prev == 15);
                    m_prev = cur;
                end else if (diff == 0) begin
                end else if (cur == 0) begin
                    m_prev = 0;
                end else begin
                    m_err   = 1;
                    m_state = ST_FAULT;
                    m_prev  = cur;
                end
                m_match = legal && (cur == int'(match_drv));
            end
            default: begin
                if (clear_drv) m_state = ST_INIT;
            end
        endcase
        if (m_wrap) begin
            if (m_cnt8 < MAX8) m_cnt8++;
            if (m_cnt2 < MAX2) m_cnt2++;
        end
        if (clear_drv) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
            m_sat8 = 0;
            m_sat2 = 0;
        end
        m_sat8 = m_sat8 | (m_cnt8 == MAX8);
        m_sat2 = m_sat2 | (m_cnt2 == MAX2);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_edge();
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit mf;
        mf = (m_state == ST_FAULT);
        check("wrap_tick8",  32'(bus8.wrap_tick),  32'(m_wrap));
        check("match_tick8", 32'(bus8.match_tick), 32'(m_match));
        check("step_err8",   32'(bus8.step_err),   32'(m_err));
        check("fault8",      32'(bus8.fault),      32'(mf));
        check("wrap_cnt8",   32'(bus8.wrap_cnt),   32'(m_cnt8));
        check("wrap_sat8",   32'(bus8.wrap_sat),   32'(m_sat8));
        check("wrap_tick2",  32'(bus2.wrap_tick),  32'(m_wrap));
        check("match_tick2", 32'(bus2.match_tick), 32'(m_match));
        check("step_err2",   32'(bus2.step_err),   32'(m_err));
        check("fault2",      32'(bus2.fault),      32'(mf));
        check("wrap_cnt2",   32'(bus2.wrap_cnt),   32'(m_cnt2));
        check("wrap_sat2",   32'(bus2.wrap_sat),   32'(m_sat2));
        if (bus8.wrap_tick === 1'b1)  obs_wraps8++;
        if (bus2.wrap_tick === 1'b1)  obs_wraps2++;
        if (bus8.match_tick === 1'b1) obs_match8++;
        if (bus8.step_err === 1'b1)   obs_err8++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tick8"},  32'(bus8.wrap_tick),  0);
        check({tag, "_match8"}, 32'(bus8.match_tick), 0);
        check({tag, "_err8"},   32'(bus8.step_err),   0);
        check({tag, "_fault8"}, 32'(bus8.fault),      0);
        check({tag, "_cnt8"},   32'(bus8.wrap_cnt),   0);
        check({tag, "_sat8"},   32'(bus8.wrap_sat),   0);
        check({tag, "_cnt2"},   32'(bus2.wrap_cnt),   0);
        check({tag, "_sat2"},   32'(bus2.wrap_sat),   0);
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, check.
    task automatic tick(input logic [3:0] qv, input logic clr);
        q_drv = qv;
        clear_drv = clr;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] cur;
        int w_before;
        int e_before;
        int m_before;
        int r;
        logic c;

        q_drv = 4'd0;
        match_drv = 4'd7;
        clear_drv = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check_all();
        reset = 1'b0;

        // Free-running counter, 40 clocks per value, two full wraps.
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 1; v <= 16; v++) begin
                repeat (40) tick(4'(v % 16), 1'b0);
            end
        end
        check("freerun_wraps", 32'(obs_wraps8), 2);
        check("freerun_cnt", 32'(bus8.wrap_cnt), 2);
        check("freerun_match7", 32'(obs_match8), 2);

        // Upstream restart from 10 straight to 0.
        for (int v = 1; v <= 10; v++) repeat (2) tick(4'(v), 1'b0);
        w_before = obs_wraps8;
        e_before = obs_err8;
        repeat (4) tick(4'd0, 1'b0);
        repeat (3) tick(4'd1, 1'b0);
        repeat (3) tick(4'd2, 1'b0);
        check("restart_no_wrap", 32'(obs_wraps8 - w_before), 0);
        check("restart_no_err", 32'(obs_err8 - e_before), 0);
        check("restart_no_fault", 32'(bus8.fault), 0);

        // Three more wraps with random hold lengths: 2-bit counter saturates.
        cur = 4'd2;
        for (int k = 0; k < 48; k++) begin
            cur = cur + 4'd1;
            repeat ($urandom_range(1, 4)) tick(cur, 1'b0);
        end
        repeat (3) tick(cur, 1'b0);
        check("sat_wraps2", 32'(obs_wraps2), 5);
        check("sat_cnt2", 32'(bus2.wrap_cnt), 3);
        check("sat_flag2", 32'(bus2.wrap_sat), 1);
        check("sat_cnt8", 32'(bus8.wrap_cnt), 5);

        // Clear on the very edge a wrap is decided.
        for (int v = 3; v <= 15; v++) repeat (2) tick(4'(v), 1'b0);
        tick(4'd0, 1'b0);
        tick(4'd0, 1'b0);
        tick(4'd0, 1'b1);
        check("clrwrap_tick", 32'(bus8.wrap_tick), 1);
        check("clrwrap_cnt8", 32'(bus8.wrap_cnt), 0);
        check("clrwrap_sat2", 32'(bus2.wrap_sat), 0);

        // Illegal 5 -> 9 jump, fault holds through a would-be wrap, then clear.
        for (int v = 1; v <= 5; v++) repeat (2) tick(4'(v), 1'b0);
        e_before = obs_err8;
        repeat (3) tick(4'd9, 1'b0);
        check("jump_err", 32'(obs_err8 - e_before), 1);
        check("jump_fault", 32'(bus8.fault), 1);
        w_before = obs_wraps8;
        m_before = obs_match8;
        for (int v = 10; v <= 24; v++) repeat (2) tick(4'(v % 16), 1'b0);
        check("fault_no_wrap", 32'(obs_wraps8 - w_before), 0);
        check("fault_no_match", 32'(obs_match8 - m_before), 0);
        check("fault_held", 32'(bus8.fault), 1);
        check("fault_cnt_held", 32'(bus8.wrap_cnt), 0);
        match_drv = 4'($urandom_range(0, 15));
        tick(4'd8, 1'b1);
        check("clear_fault", 32'(bus8.fault), 0);
        check("clear_cnt", 32'(bus8.wrap_cnt), 0);
        repeat (3) tick(4'd8, 1'b0);
        cur = 4'd8;

        // Random walk with restarts, jumps and occasional clears.
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            c = 1'b0;
            if (r < 55) begin
                cur = cur + 4'd1;
            end else if (r < 80) begin
            end else if (r < 88) begin
                cur = 4'd0;
            end else if (r < 95) begin
                cur = 4'($urandom_range(0, 15));
            end else begin
                c = 1'b1;
                match_drv = 4'($urandom_range(0, 15));
            end
            tick(cur, c);
        end

        // Reset asserted between edges acts at once; tracking resumes afterwards.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        check("midreset_tick2", 32'(bus2.wrap_tick), 0);
        check("midreset_fault2", 32'(bus2.fault), 0);
        @(negedge clk);
        match_drv = 4'd4;
        repeat (2) tick(4'd3, 1'b0);
        reset = 1'b0;
        repeat (2) tick(4'd3, 1'b0);
        tick(4'd4, 1'b0);
        tick(4'd4, 1'b0);
        tick(4'd4, 1'b0);
        check("resume_match", 32'(bus8.match_tick), 1);
        check("resume_fault", 32'(bus8.fault), 0);
        repeat (3) tick(4'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/four_bit_wrap_monitor.md
FOUR_BIT_WRAP_MONITOR -- requirements
Module: four_bit_wrap_monitor

Interface
REQ-001 Parameter WRAP_W, default 8, width of the wrap-event counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 q  input  4  count value from the upstream 4-bit up counter, asynchronous to clk.
REQ-005 match  input  4  compare value for match_tick; static or changed only when clear is asserted.
REQ-006 clear  input  1  synchronous clear of counters and fault.
REQ-007 wrap_tick  output  1  one-cycle pulse per legal 15->0 transition.
REQ-008 match_tick  output  1  one-cycle pulse per legal step landing on match.
REQ-009 wrap_cnt  output  WRAP_W  number of wraps since reset/clear, saturating.
REQ-010 wrap_sat  output  1  sticky; wrap_cnt has reached all-ones.
REQ-011 step_err  output  1  one-cycle pulse on an illegal step.
REQ-012 fault  output  1  high while in FAULT.

Function
REQ-013 q SHALL pass through a 2-flop sampler (s1, s2); all decisions use s2 and a registered previous value prev.
REQ-014 States SHALL be INIT, TRACK and FAULT.
REQ-015 INIT: on the first edge with s2 valid (2nd edge after reset release), load prev, go TRACK, no pulses.
REQ-016 TRACK, s2 == prev: no action.
REQ-017 TRACK, s2 == prev+1 mod 16: legal step; prev <= s2.
REQ-018 TRACK, prev == 15 and s2 == 0: legal wrap; wrap_tick = 1 for one cycle; wrap_cnt increments.
REQ-019 TRACK, s2 == 0 and prev not in {15, 0}: upstream restart; resync prev, no wrap, no error.
REQ-020 TRACK, any other transition: step_err = 1 for one cycle, go FAULT, prev <= s2.
REQ-021 match_tick SHALL pulse only on a legal step or wrap (REQ-017/018) whose s2 equals match.
REQ-022 Latency: a q change captured into s1 at edge N SHALL produce its pulse in the cycle after edge N+2.
REQ-023 wrap_cnt SHALL saturate at 2^WRAP_W-1, set wrap_sat, and ignore further wraps (wrap_tick still pulses).
REQ-024 FAULT: wrap_tick/match_tick suppressed, wrap_cnt held, fault = 1; leave only via clear.
REQ-025 clear SHALL zero wrap_cnt and wrap_sat, and move FAULT -> INIT; in TRACK the state is kept.
REQ-026 clear coincident with a wrap: clear wins on wrap_cnt (result 0); wrap_tick still pulses.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 reset SHALL clear s1, s2, prev, wrap_cnt, wrap_sat, wrap_tick, match_tick, step_err and fault to 0, and set state INIT.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, without waiting for clk; after release, REQ-015 applies.

Structure
REQ-030 State codes INIT=2'b00, TRACK=2'b01 and FAULT=2'b10 SHALL live in a shared definitions file, counter_mon_defs, reused by the bench.
REQ-031 The 2-flop sampler SHALL be a sub-module, q_sync2 (4 bits wide, with async reset).

Verification
REQ-032 Free-running upstream counter 0..15..0 for 40 clk periods per step -> exactly one wrap_tick per wrap, wrap_cnt = 2 after two wraps.
REQ-033 match = 4'd7 -> one match_tick per pass through 7, 3 cycles after q = 7 is sampled.
REQ-034 Force q 5 -> 9 -> step_err pulse, fault = 1, no further ticks; clear -> INIT, fault = 0, wrap_cnt = 0.
REQ-035 Upstream reset from q = 10 to q = 0 -> no wrap_tick, no step_err, tracking continues from 0.
REQ-036 WRAP_W = 2, 5 wraps -> wrap_cnt = 3, wrap_sat = 1, wrap_tick pulsing 5 times.
REQ-037 Assert reset mid-count between clk edges -> all outputs 0 before the next edge; 2 edges after release, tracking resumes.
